// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad event queue: FSM states, the no-key code,
// default timing values and saturating counter helpers.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } kp_state_t;

  localparam logic [7:0] NO_KEY = 8'h00;

  localparam int DEF_DEBOUNCE_MS     = 20;
  localparam int DEF_FIFO_DEPTH      = 4;
  localparam int DEF_REPEAT_DELAY_MS = 500;
  localparam int DEF_REPEAT_RATE_MS  = 100;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Small synchronous event queue with separate occupancy count; head is
// presented combinationally from storage.
module event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == {(AW + 1){1'b0}});
  assign do_pop  = pop & ~empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {(AW + 1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1'b1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1'b1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1'b1);
        2'b01:   count <= count - (AW + 1)'(1'b1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keypad_event_queue.sv
// Keypad debouncer feeding an event queue. Define KEYPAD_REPEAT_EN to enable
// auto-repeat of a held key.
module keypad_event_queue
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_MS     = DEF_DEBOUNCE_MS,
  parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
  parameter int REPEAT_DELAY_MS = DEF_REPEAT_DELAY_MS,
  parameter int REPEAT_RATE_MS  = DEF_REPEAT_RATE_MS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  keypad,
  input  logic [31:0] timer,
  output logic [7:0]  key_code,
  output logic        key_valid,
  input  logic        key_ack,
  output logic        overflow
);

  localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_MS);

  logic [31:0] timer_q;
  logic        tick;
  logic [7:0]  sample;
  kp_state_t   state, state_nx;
  logic [7:0]  cand, cand_nx;
  logic [7:0]  cnt, cnt_nx;
  logic        fsm_push;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;

  assign tick      = (timer != timer_q);
  assign key_valid = ~empty;
  assign pop       = key_ack & key_valid;

  // Timer edge detect, keypad sample, FSM state and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q  <= timer;  // track during reset so release does not fake a tick
      sample   <= NO_KEY;
      state    <= IDLE;
      cand     <= NO_KEY;
      cnt      <= 8'd0;
      overflow <= 1'b0;
    end else begin
      timer_q  <= timer;
      sample   <= keypad;
      state    <= state_nx;
      cand     <= cand_nx;
      cnt      <= cnt_nx;
      overflow <= overflow | (push & full & ~pop);
    end
  end

  // Debounce next-state logic.
  always_comb begin
    state_nx = state;
    cand_nx  = cand;
    cnt_nx   = cnt;
    fsm_push = 1'b0;
    case (state)
      IDLE: begin
        if (sample != NO_KEY) begin
          cand_nx  = sample;
          cnt_nx   = 8'd0;
          state_nx = DEBOUNCE;
        end else begin
          state_nx = IDLE;
        end
      end
      DEBOUNCE: begin
        if (sample == NO_KEY) begin
          cnt_nx   = 8'd0;
          state_nx = IDLE;
        end else if (sample != cand) begin
          cand_nx = sample;
          cnt_nx  = 8'd0;
        end else if (tick) begin
          if (sat_inc8(cnt) == DB_LIMIT) begin
            fsm_push = 1'b1;
            cnt_nx   = 8'd0;
            state_nx = HELD;
          end else begin
            cnt_nx = sat_inc8(cnt);
          end
        end else begin
          cnt_nx = cnt;
        end
      end
      HELD: begin
        if (sample != cand) begin
          cnt_nx   = 8'd0;
          state_nx = RELEASE;
        end else begin
          state_nx = HELD;
        end
      end
      RELEASE: begin
        if (sample == cand) begin
          state_nx = HELD;
        end else if (tick) begin
          if (sat_inc8(cnt) == DB_LIMIT) begin
            cnt_nx   = 8'd0;
            state_nx = IDLE;
          end else begin
            cnt_nx = sat_inc8(cnt);
          end
        end else begin
          cnt_nx = cnt;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 8'd0;
      end
    endcase
  end

`ifdef KEYPAD_REPEAT_EN
  localparam logic [15:0] REP_DELAY = 16'(REPEAT_DELAY_MS);
  localparam logic [15:0] REP_RATE  = 16'(REPEAT_RATE_MS);

  logic [15:0] rep_cnt, rep_cnt_nx;
  logic        rep_first, rep_first_nx;
  logic        rep_push;

  // Repeat timer runs only while the accepted code stays held; anything else rearms it.
  always_comb begin
    rep_cnt_nx   = 16'd0;
    rep_first_nx = 1'b1;
    rep_push     = 1'b0;
    if ((state == HELD) && (sample == cand)) begin
      rep_first_nx = rep_first;
      if (tick) begin
        if (sat_inc16(rep_cnt) == (rep_first ? REP_DELAY : REP_RATE)) begin
          rep_push     = 1'b1;
          rep_cnt_nx   = 16'd0;
          rep_first_nx = 1'b0;
        end else begin
          rep_cnt_nx = sat_inc16(rep_cnt);
        end
      end else begin
        rep_cnt_nx = rep_cnt;
      end
    end else begin
      rep_cnt_nx   = 16'd0;
      rep_first_nx = 1'b1;
    end
  end

  // Repeat timer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt   <= 16'd0;
      rep_first <= 1'b1;
    end else begin
      rep_cnt   <= rep_cnt_nx;
      rep_first <= rep_first_nx;
    end
  end

  assign push = fsm_push | rep_push;
`else
  logic [31:0] unused_repeat_cfg;
  assign unused_repeat_cfg = 32'(REPEAT_DELAY_MS) ^ 32'(REPEAT_RATE_MS);
  assign push = fsm_push;
`endif

  event_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (cand),
    .pop   (pop),
    .dout  (key_code),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_keypad_event_queue.sv
// Directed self-checking bench for keypad_event_queue; one timer tick every two
// clocks, expected values hand-computed from the debounce/queue rules.
module tb_keypad_event_queue;

  logic        clk;
  logic        rst;
  logic [7:0]  keypad;
  logic [31:0] timer;
  logic [7:0]  key_code;
  logic        key_valid;
  logic        key_ack;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  keypad_event_queue #(
    .DEBOUNCE_MS     (20),
    .FIFO_DEPTH      (4),
    .REPEAT_DELAY_MS (500),
    .REPEAT_RATE_MS  (100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .keypad    (keypad),
    .timer     (timer),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      timer = timer + 32'd1;
      cyc(2);
    end
  endtask

  task automatic ack();
    key_ack = 1'b1;
    cyc(1);
    key_ack = 1'b0;
  endtask

  // Hold code until its 20th tick; optionally ack on the very edge of the push.
  task automatic press(input logic [7:0] code, input logic ack_on_push);
    keypad = code;
    cyc(2);
    ticks(19);
    timer   = timer + 32'd1;
    key_ack = ack_on_push;
    cyc(1);
    key_ack = 1'b0;
    cyc(1);
  endtask

  task automatic release_key();
    keypad = 8'h00;
    ticks(21);
  endtask

  initial begin
    rst     = 1'b1;
    keypad  = 8'h00;
    timer   = 32'd0;
    key_ack = 1'b0;
    cyc(3);
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    cyc(2);

    // Stable press: event exactly on tick 20, single event over 25 ticks.
    keypad = 8'h41;
    cyc(2);
    ticks(19);
    check("t1_tick19_valid", key_valid, 0);
    timer = timer + 32'd1;
    cyc(1);
    check("t1_tick20_valid", key_valid, 1);
    check("t1_tick20_code", key_code, 8'h41);
    cyc(1);
    ticks(5);
    ack();
    check("t1_single_event", key_valid, 0);
    release_key();
    check("t1_no_release_event", key_valid, 0);

    // Bouncing key never settles long enough.
    for (int i = 0; i < 5; i++) begin
      keypad = 8'h41;
      ticks(3);
      keypad = 8'h00;
      ticks(3);
    end
    ticks(25);
    check("t2_bounce_valid", key_valid, 0);
    check("t2_bounce_ovf", overflow, 0);

    // Five presses into a depth-4 queue without ack.
    for (int i = 0; i < 5; i++) begin
      press(8'h31 + 8'(i), 1'b0);
      release_key();
      if (i == 3) check("t3_full_no_ovf", overflow, 0);
    end
    check("t3_ovf_set", overflow, 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_pop%0d", i), key_code, 8'h31 + 8'(i));
      ack();
    end
    check("t3_drained", key_valid, 0);
    check("t3_ovf_sticky", overflow, 1);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    check("t3_rst_ovf", overflow, 0);
    check("t3_rst_valid", key_valid, 0);
    cyc(2);

    // Full queue with pop on the push edge.
    for (int i = 0; i < 4; i++) begin
      press(8'h31 + 8'(i), 1'b0);
      release_key();
    end
    check("t4_full_head", key_code, 8'h31);
    press(8'h35, 1'b1);
    check("t4_ovf_clear", overflow, 0);
    check("t4_head_after", key_code, 8'h32);
    release_key();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t4_pop%0d", i), key_code, 8'h32 + 8'(i));
      ack();
    end
    check("t4_last_entry", key_code, 8'h35);
    press(8'h36, 1'b1);
    check("t4_one_entry_valid", key_valid, 1);
    check("t4_one_entry_code", key_code, 8'h36);
    release_key();
    ack();
    check("t4_empty", key_valid, 0);
    ack();
    check("t4_ack_empty_ignored", key_valid, 0);
    press(8'h37, 1'b0);
    check("t4_after_ignored_code", key_code, 8'h37);
    ack();
    check("t4_after_ignored_empty", key_valid, 0);
    release_key();

    // Reset mid-debounce with a queued event; held key re-debounced once.
    press(8'h50, 1'b0);
    release_key();
    keypad = 8'h41;
    cyc(2);
    ticks(10);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    check("t5_rst_valid", key_valid, 0);
    check("t5_rst_code", key_code, 0);
    check("t5_rst_ovf", overflow, 0);
    cyc(2);
    ticks(19);
    check("t5_tick19_valid", key_valid, 0);
    timer = timer + 32'd1;
    cyc(1);
    check("t5_tick20_valid", key_valid, 1);
    check("t5_tick20_code", key_code, 8'h41);
    cyc(1);
    ack();
    ticks(5);
    check("t5_single", key_valid, 0);
    release_key();

    // Long hold: repeats only with the feature enabled.
    keypad = 8'h20;
    cyc(2);
    ticks(19);
    timer = timer + 32'd1;
    cyc(1);
    check("t6_first_valid", key_valid, 1);
    check("t6_first_code", key_code, 8'h20);
    ack();
`ifdef KEYPAD_REPEAT_EN
    for (int i = 0; i < 3; i++) begin
      ticks(((i == 0) ? 500 : 100) - 1);
      check($sformatf("t6_rep%0d_before", i), key_valid, 0);
      timer = timer + 32'd1;
      cyc(1);
      check($sformatf("t6_rep%0d_valid", i), key_valid, 1);
      check($sformatf("t6_rep%0d_code", i), key_code, 8'h20);
      ack();
    end
`else
    ticks(700);
    check("t6_no_repeat", key_valid, 0);
`endif
    release_key();
    check("t6_end_ovf", overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
